// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU feeder blocks: FSM state encoding and phase lengths.
package tpu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StFeed,
    StDrain,
    StDone
  } feeder_state_e;

  localparam int unsigned FEED_CYCLES  = 3;
  localparam int unsigned DRAIN_CYCLES = 3;

endpackage

// File: rtl/systolic_feeder_2x2.sv
// 2x2 systolic array feeder: stores matrices A and B and streams them into the array
// with a one-cycle skew per row/column, framed by a clear cycle and a drain period.
// Optional build macro TPU_FEEDER_STATS_EN adds a 16-bit completed-operation counter.
module systolic_feeder_2x2
  import tpu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_en_i,
  input  logic             load_sel_i,
  input  logic [1:0]       load_addr_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             clear_o,
  output logic [WIDTH-1:0] a_data0_o,
  output logic [WIDTH-1:0] a_data1_o,
  output logic [WIDTH-1:0] b_data0_o,
`ifdef TPU_FEEDER_STATS_EN
  output logic [WIDTH-1:0] b_data1_o,
  output logic [15:0]      op_count_o
`else
  output logic [WIDTH-1:0] b_data1_o
`endif
);

  localparam logic [1:0] FeedLast  = 2'(FEED_CYCLES - 1);
  localparam logic [1:0] DrainLast = 2'(DRAIN_CYCLES - 1);

  feeder_state_e    state_q, state_d;
  // Shared step counter: FEED step s, then reused for the drain count.
  logic [1:0]       cnt_q, cnt_d;
  // Elements stored row-major: index = row*2 + col.
  logic [WIDTH-1:0] mat_a_q [4];
  logic [WIDTH-1:0] mat_b_q [4];

  // Matrix storage; writes accepted only while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        mat_a_q[i] <= '0;
        mat_b_q[i] <= '0;
      end
    end else if (load_en_i && (state_q == StIdle)) begin
      if (load_sel_i) begin
        mat_b_q[load_addr_i] <= load_data_i;
      end else begin
        mat_a_q[load_addr_i] <= load_data_i;
      end
    end
  end

  // State and step counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; DONE chains straight into CLR when start is held, keeping an
  // 8-cycle period for back-to-back operations.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StClr;
          cnt_d   = '0;
        end
      end
      StClr: begin
        state_d = StFeed;
        cnt_d   = '0;
      end
      StFeed: begin
        if (cnt_q == FeedLast) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StDone: begin
        state_d = start_i ? StClr : StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: skewed streams during FEED, zeros everywhere else.
  always_comb begin
    busy_o    = (state_q != StIdle);
    done_o    = (state_q == StDone);
    clear_o   = (state_q == StClr);
    a_data0_o = '0;
    a_data1_o = '0;
    b_data0_o = '0;
    b_data1_o = '0;
    if (state_q == StFeed) begin
      unique case (cnt_q)
        2'd0: begin
          a_data0_o = mat_a_q[0];
          b_data0_o = mat_b_q[0];
        end
        2'd1: begin
          a_data0_o = mat_a_q[1];
          a_data1_o = mat_a_q[2];
          b_data0_o = mat_b_q[2];
          b_data1_o = mat_b_q[1];
        end
        2'd2: begin
          a_data1_o = mat_a_q[3];
          b_data1_o = mat_b_q[3];
        end
        default: ;
      endcase
    end
  end

`ifdef TPU_FEEDER_STATS_EN
  logic [15:0] op_count_q;

  // Completed-operation counter, wraps naturally at 16 bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_count_q <= '0;
    end else if (state_q == StDone) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count_o = op_count_q;
`endif

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Scoreboard bench for systolic_feeder_2x2 with a behavioural downstream 2x2 array.
module tb_systolic_feeder_2x2;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         load_en_i = 1'b0;
  logic         load_sel_i = 1'b0;
  logic [1:0]   load_addr_i = '0;
  logic [W-1:0] load_data_i = '0;
  logic         start_i = 1'b0;
  logic         busy_o, done_o, clear_o;
  logic [W-1:0] a_data0_o, a_data1_o, b_data0_o, b_data1_o;
`ifdef TPU_FEEDER_STATS_EN
  logic [15:0]  op_count_o;
`endif

  systolic_feeder_2x2 #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .load_en_i   (load_en_i),
    .load_sel_i  (load_sel_i),
    .load_addr_i (load_addr_i),
    .load_data_i (load_data_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .clear_o     (clear_o),
    .a_data0_o   (a_data0_o),
    .a_data1_o   (a_data1_o),
    .b_data0_o   (b_data0_o),
`ifdef TPU_FEEDER_STATS_EN
    .b_data1_o   (b_data1_o),
    .op_count_o  (op_count_o)
`else
    .b_data1_o   (b_data1_o)
`endif
  );

  always #5 clk = ~clk;

  // Downstream output-stationary 2x2 array: a flows right, b flows down.
  logic [31:0]  c_q [4] = '{default: 32'd0};
  logic [W-1:0] a00_q = '0, a10_q = '0, b00_q = '0, b01_q = '0;

  always @(posedge clk) begin
    if (clear_o) begin
      for (int i = 0; i < 4; i++) c_q[i] <= 32'd0;
    end else begin
      c_q[0] <= c_q[0] + 32'(a_data0_o) * 32'(b_data0_o);
      c_q[1] <= c_q[1] + 32'(a00_q) * 32'(b_data1_o);
      c_q[2] <= c_q[2] + 32'(a_data1_o) * 32'(b00_q);
      c_q[3] <= c_q[3] + 32'(a10_q) * 32'(b01_q);
    end
    a00_q <= a_data0_o;
    b00_q <= b_data0_o;
    a10_q <= a_data1_o;
    b01_q <= b_data1_o;
  end

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         clear;
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [W-1:0] b0;
    logic [W-1:0] b1;
  } obs_t;

  obs_t         exp_q [$];
  logic [W-1:0] ma [4];
  logic [W-1:0] mb [4];
  int           checks = 0;
  int           errors = 0;
  int           done_at [$];

  function automatic obs_t cur_obs();
    obs_t o;
    o.busy  = busy_o;
    o.done  = done_o;
    o.clear = clear_o;
    o.a0    = a_data0_o;
    o.a1    = a_data1_o;
    o.b0    = b_data0_o;
    o.b1    = b_data1_o;
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle outputs of one sequence, built from the model matrices.
  task automatic push_seq();
    obs_t e;
    e = '0; e.busy = 1'b1; e.clear = 1'b1; exp_q.push_back(e);
    e = '0; e.busy = 1'b1; e.a0 = ma[0]; e.b0 = mb[0]; exp_q.push_back(e);
    e = '0; e.busy = 1'b1; e.a0 = ma[1]; e.a1 = ma[2]; e.b0 = mb[2]; e.b1 = mb[1];
    exp_q.push_back(e);
    e = '0; e.busy = 1'b1; e.a1 = ma[3]; e.b1 = mb[3]; exp_q.push_back(e);
    for (int i = 0; i < 3; i++) begin
      e = '0; e.busy = 1'b1; exp_q.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    obs_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(cur_obs()), 64'(e));
    end
  endtask

  task automatic step_check(input string tag);
    @(negedge clk);
    pop_check(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [1:0] addr, input logic [W-1:0] data);
    load_en_i = 1'b1; load_sel_i = sel; load_addr_i = addr; load_data_i = data;
    @(posedge clk);
    #1;
    load_en_i = 1'b0;
    if (sel) mb[addr] = data; else ma[addr] = data;
  endtask

  task automatic load_all();
    for (int i = 0; i < 4; i++) load(1'b0, 2'(i), W'(i + 1));
    for (int i = 0; i < 4; i++) load(1'b1, 2'(i), W'(i + 5));
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    exp_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    for (int i = 0; i < 4; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    #12;
    check("reset_outputs", 64'(cur_obs()), 64'd0);
`ifdef TPU_FEEDER_STATS_EN
    check("reset_op_count", 64'(op_count_o), 64'd0);
`endif
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Basic feed and downstream array result.
    load_all();
    pulse_start();
    push_seq();
    for (int i = 0; i < 8; i++) step_check("basic");
    @(negedge clk);
    check("basic_idle", 64'(cur_obs()), 64'd0);
    check("array_c00", 64'(c_q[0]), 64'd19);
    check("array_c01", 64'(c_q[1]), 64'd22);
    check("array_c10", 64'(c_q[2]), 64'd43);
    check("array_c11", 64'(c_q[3]), 64'd50);
    @(posedge clk);
    #1;

    // Write attempted during FEED must be dropped.
    pulse_start();
    push_seq();
    step_check("busy_load");
    step_check("busy_load");
    load_en_i = 1'b1; load_sel_i = 1'b0; load_addr_i = 2'd0; load_data_i = 8'd9;
    step_check("busy_load");
    load_en_i = 1'b0;
    for (int i = 0; i < 5; i++) step_check("busy_load");
    pulse_start();
    push_seq();
    for (int i = 0; i < 8; i++) step_check("after_busy_load");

    // Reset during DRAIN aborts immediately and clears the matrices.
    pulse_start();
    push_seq();
    for (int i = 0; i < 5; i++) step_check("pre_reset");
    #1;
    rst_ni = 1'b0;
    #1;
    check("reset_mid_outputs", 64'(cur_obs()), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    @(negedge clk);
    check("reset_mid_held", 64'(cur_obs()), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    pulse_start();
    push_seq();
    for (int i = 0; i < 8; i++) step_check("zero_feed");

    // Back-to-back with start held high.
    do_reset();
    load_all();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    push_seq();
    push_seq();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i < 16) pop_check("b2b");
      if (done_o) done_at.push_back(i);
`ifdef TPU_FEEDER_STATS_EN
      if (i == 16) check("b2b_op_count", 64'(op_count_o), 64'd2);
`endif
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    check("b2b_done_count", 64'(done_at.size()), 64'd2);
    if (done_at.size() >= 2) check("b2b_done_spacing", 64'(done_at[1] - done_at[0]), 64'd8);
    waited = 0;
    while (busy_o && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("b2b_return_idle", 64'(busy_o), 64'd0);

    // Load and start on the same edge: new value is used in FEED.
    load_en_i = 1'b1; load_sel_i = 1'b0; load_addr_i = 2'd3; load_data_i = 8'd7;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    load_en_i = 1'b0;
    start_i = 1'b0;
    ma[3] = 8'd7;
    push_seq();
    for (int i = 0; i < 8; i++) step_check("load_and_start");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder_2x2.md
SYSTOLIC_FEEDER_2X2 -- requirements
Module: systolic_feeder_2x2

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width of every matrix element and data output.
REQ-002 SHALL have one clock and asynchronous active-low reset: clk input 1 (sole clock); rst input 1 (asynchronous, active-low).
REQ-003 SHALL have load_en input 1: write one matrix element this cycle.
REQ-004 SHALL have load_sel input 1: 0 selects matrix A, 1 selects matrix B.
REQ-005 SHALL have load_addr input 2: element index, row*2+col.
REQ-006 SHALL have load_data input WIDTH: element value.
REQ-007 SHALL have start input 1: request one matrix-multiply feed sequence.
REQ-008 SHALL have busy output 1: sequence in progress.
REQ-009 SHALL have done output 1: single-cycle completion pulse.
REQ-010 SHALL have clear output 1: accumulator clear toward the array.
REQ-011 SHALL have four WIDTH-bit outputs a_data0, a_data1, b_data0, b_data1: skewed row/column streams toward the array.

Function
REQ-012 SHALL store A[2][2] and B[2][2] in internal registers; a write with load_en=1 while busy=0 SHALL update the addressed element at the clock edge.
REQ-013 SHALL ignore load_en while busy=1, leaving both matrices unchanged.
REQ-014 SHALL implement FSM IDLE -> CLR -> FEED -> DRAIN -> DONE -> IDLE.
REQ-015 SHALL leave IDLE only when start=1 is sampled at a clock edge in IDLE; start in any other state SHALL be ignored.
REQ-016 SHALL spend 1 cycle in CLR with clear=1 and all data outputs 0.
REQ-017 SHALL spend 3 cycles in FEED, with step s = 0, 1, 2.
- a_data0 = A[0][s] for s ≤ 1, else 0.
- a_data1 = A[1][s-1] for s ≥ 1, else 0.
- b_data0 = B[s][0] for s ≤ 1, else 0.
- b_data1 = B[s-1][1] for s ≥ 1, else 0.
REQ-018 SHALL spend 3 cycles in DRAIN with all data outputs 0.
REQ-019 SHALL spend 1 cycle in DONE with done=1, then return to IDLE.
REQ-020 SHALL drive busy=1 in every state except IDLE.
REQ-021 SHALL drive clear=0 and all data outputs 0 outside CLR and FEED.
REQ-022 SHALL make a load_en write and start sampled at the same edge in IDLE both take effect, with the written value used in FEED.
REQ-023 SHALL, with start held high continuously, begin a new sequence on the cycle after DONE, giving an 8-cycle period.
REQ-024 SHALL use the stored matrices unmodified; no arithmetic and no sign handling is performed.

Reset
REQ-025 SHALL, on rst=0, immediately force:
- state IDLE and step 0;
- busy=0, done=0, clear=0;
- all data outputs 0;
- all A and B elements 0.
REQ-026 SHALL abort any sequence in progress when reset is asserted mid-sequence, without a done pulse.

Configuration
REQ-027 SHALL, with macro TPU_FEEDER_STATS_EN defined, add output op_count (16 bits).
- Reset value 0.
- Increments by 1 on each DONE cycle.
- Wraps from 65535 to 0.
REQ-028 SHALL, without TPU_FEEDER_STATS_EN, have neither the op_count port nor its counter.

Structure
REQ-029 SHALL take the following from shared package tpu_pkg:
- the FSM state enumeration;
- constants FEED_CYCLES=3 and DRAIN_CYCLES=3.
REQ-030 SHALL be a single module with no sub-module; step/drain counting SHALL use one shared 2-bit counter.

Verification
REQ-031 SHALL cover basic feed: load A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse start. The bench SHALL check, per cycle after the start edge:
- CLR: clear=1, all data 0.
- FEED s0: a0=1, a1=0, b0=5, b1=0.
- FEED s1: a0=2, a1=3, b0=7, b1=6.
- FEED s2: a0=0, a1=4, b0=0, b1=8.
- Then 3 zero cycles, then done=1.
REQ-032 SHALL cover array integration: the same stimulus drives a downstream 2x2 array; after done, its outputs SHALL read C=[[19,22],[43,50]].
REQ-033 SHALL cover load-while-busy: write A[0][0]=9 during FEED; the next sequence SHALL still feed a_data0=1 at s0.
REQ-034 SHALL cover reset mid-sequence: assert rst=0 during DRAIN. The bench SHALL check:
- busy=0, done=0, all outputs 0 immediately;
- a subsequent start feeds all-zero matrices.
REQ-035 SHALL cover back-to-back: hold start=1 for 20 cycles and check:
- done pulses at 8-cycle spacing;
- with TPU_FEEDER_STATS_EN, op_count=2 after two DONE cycles.
REQ-036 SHALL cover simultaneous load and start: in IDLE, assert load_en (A[1][1]=7) together with start; FEED s2 SHALL drive a_data1=7.
